// File: rtl/dsp_pkg.sv
// Shared DSP types: FFT output control word, integrator FSM states, FFT length.
package dsp_pkg;

   localparam int FFT32_LENGTH = 32;

   typedef struct packed {
      logic       valid;
      logic       last;
      logic       reverse;
      logic [4:0] data_index;
      logic [7:0] tag;
   } fft32_control_t;

   typedef enum logic [1:0] {
      S_FIRST  = 2'd0,
      S_ACCUM  = 2'd1,
      S_LAST   = 2'd2,
      S_RESYNC = 2'd3
   } fft32_power_integ_state_t;

endpackage

// File: rtl/fft_32_power_integrator_if.sv
// FFT-bin stream in, averaged spectrum stream out.
interface fft_32_power_integrator_if #(
   parameter int INPUT_DATA_WIDTH = 21,
   parameter int OUTPUT_WIDTH     = 2*INPUT_DATA_WIDTH
);
   dsp_pkg::fft32_control_t              Input_control;
   logic signed [INPUT_DATA_WIDTH-1:0]   Input_i;
   logic signed [INPUT_DATA_WIDTH-1:0]   Input_q;
   logic                                 Output_valid;
   logic [4:0]                           Output_index;
   logic                                 Output_last;
   logic                                 Output_reverse;
   logic [7:0]                           Output_tag;
   logic [OUTPUT_WIDTH-1:0]              Output_power;
   logic                                 Error_index;

   modport master (
      output Input_control, Input_i, Input_q,
      input  Output_valid, Output_index, Output_last, Output_reverse,
             Output_tag, Output_power, Error_index
   );

   modport slave (
      input  Input_control, Input_i, Input_q,
      output Output_valid, Output_index, Output_last, Output_reverse,
             Output_tag, Output_power, Error_index
   );
endinterface

// File: rtl/fft_32_power_calc.sv
// Two-stage registered i^2 + q^2 with the control word carried alongside.
module fft_32_power_calc
   import dsp_pkg::*;
#(
   parameter int DATA_WIDTH = 21
) (
   input  logic                          Clk,
   input  logic                          Rst,
   input  fft32_control_t                Ctrl_i,
   input  logic signed [DATA_WIDTH-1:0]  I_i,
   input  logic signed [DATA_WIDTH-1:0]  Q_i,
   output fft32_control_t                Ctrl_o,
   output logic [2*DATA_WIDTH-1:0]       Power_o
);
   localparam int PW = 2*DATA_WIDTH;

   logic signed [PW-1:0] ii_d, qq_d;
   logic [PW-1:0]        ii_q, qq_q, power_q;
   fft32_control_t       ctrl1_q, ctrl2_q;

   // Squares are non-negative, so the signed products can be held unsigned.
   assign ii_d = I_i * I_i;
   assign qq_d = Q_i * Q_i;

   // Stage 1 squares, stage 2 sum; only the valid bits need clearing on reset.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         ctrl1_q <= '0;
         ctrl2_q <= '0;
      end else begin
         ctrl1_q <= Ctrl_i;
         ii_q    <= ii_d;
         qq_q    <= qq_d;
         ctrl2_q <= ctrl1_q;
         power_q <= ii_q + qq_q;
      end
   end

   assign Ctrl_o  = ctrl2_q;
   assign Power_o = power_q;
endmodule

// File: rtl/fft_32_power_integrator.sv
// Per-bin power integration over 2^N FFT frames with averaged spectrum output.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_FIRST  | first frame: latch N on bin 0, overwrite RAM (emit if N=0)
//   S_ACCUM  | middle frames: RAM += power, count frames
//   S_LAST   | final frame: emit (RAM + power) >> N
//   S_RESYNC | index error seen: discard, wait for a last sample
module fft_32_power_integrator
   import dsp_pkg::*;
#(
   parameter int INPUT_DATA_WIDTH = 21,
   parameter int MAX_FRAMES_LOG2  = 8,
   parameter int OUTPUT_WIDTH     = 2*INPUT_DATA_WIDTH,
   localparam int NW              = $clog2(MAX_FRAMES_LOG2+1)
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [NW-1:0]        Num_frames_log2,
   fft_32_power_integrator_if.slave bus
);
   localparam int PW = 2*INPUT_DATA_WIDTH;
   localparam int AW = PW + MAX_FRAMES_LOG2;
   localparam int CW = MAX_FRAMES_LOG2 + 1;
   localparam logic [NW-1:0] N_MAX = NW'(MAX_FRAMES_LOG2);

   fft32_control_t            ctrl2;
   logic [PW-1:0]             power2;
   fft32_power_integ_state_t  state_q, state_d;
   logic [4:0]                exp_idx_q, exp_idx_d;
   logic [NW-1:0]             n_q, n_d, n_clamped, n_eff;
   logic [CW-1:0]             frame_cnt_q, frame_cnt_d, cnt_inc;
   logic [CW:0]               frames_total;
   logic                      idx_err;
   logic                      wr_d, emit_d, err_d;
   logic [AW-1:0]             sum_d, ram_rd;
   logic [AW-1:0]             acc_ram [FFT32_LENGTH];
   logic                      wr_q, emit_q, err_q;
   fft32_control_t            ctrl3_q;
   logic [AW-1:0]             sum_q;
   logic [NW-1:0]             shift_q;
   logic                      out_valid_q, out_err_q, out_last_q, out_rev_q;
   logic [4:0]                out_idx_q;
   logic [7:0]                out_tag_q;
   logic [OUTPUT_WIDTH-1:0]   out_power_q;

   fft_32_power_calc #(.DATA_WIDTH(INPUT_DATA_WIDTH)) u_power_calc (
      .Clk     (Clk),
      .Rst     (Rst),
      .Ctrl_i  (bus.Input_control),
      .I_i     (bus.Input_i),
      .Q_i     (bus.Input_q),
      .Ctrl_o  (ctrl2),
      .Power_o (power2)
   );

   assign n_clamped    = (Num_frames_log2 > N_MAX) ? N_MAX : Num_frames_log2;
   // Bin 0 of the first frame uses the fresh N before it has been latched.
   assign n_eff        = (state_q == S_FIRST && ctrl2.data_index == 5'd0) ? n_clamped : n_q;
   assign idx_err      = (ctrl2.data_index != exp_idx_q) || (ctrl2.last != (ctrl2.data_index == 5'd31));
   assign cnt_inc      = frame_cnt_q + CW'(1);
   assign frames_total = (CW+1)'(1) << n_q;
   assign ram_rd       = acc_ram[ctrl2.data_index];

   // FSM state and sequencing registers.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q     <= S_FIRST;
         exp_idx_q   <= '0;
         n_q         <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         exp_idx_q   <= exp_idx_d;
         n_q         <= n_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Next-state: index tracking, frame counting, integration sequencing.
   always_comb begin
      state_d     = state_q;
      exp_idx_d   = exp_idx_q;
      n_d         = n_q;
      frame_cnt_d = frame_cnt_q;
      if (ctrl2.valid) begin
         if (state_q == S_RESYNC) begin
            if (ctrl2.last) begin
               state_d   = S_FIRST;
               exp_idx_d = '0;
            end
         end else if (idx_err) begin
            state_d   = ctrl2.last ? S_FIRST : S_RESYNC;
            exp_idx_d = '0;
         end else begin
            exp_idx_d = exp_idx_q + 5'd1;
            case (state_q)
               S_FIRST: begin
                  if (ctrl2.data_index == 5'd0) n_d = n_clamped;
                  if (ctrl2.last) begin
                     frame_cnt_d = '0;
                     if (n_eff == '0)      state_d = S_FIRST;
                     else if (n_eff == 1)  state_d = S_LAST;
                     else                  state_d = S_ACCUM;
                  end
               end
               S_ACCUM: begin
                  if (ctrl2.last) begin
                     frame_cnt_d = cnt_inc;
                     if ({1'b0, cnt_inc} == frames_total - (CW+1)'(2)) state_d = S_LAST;
                  end
               end
               S_LAST: begin
                  if (ctrl2.last) state_d = S_FIRST;
               end
               default: state_d = S_RESYNC;
            endcase
         end
      end
   end

   // Outputs: RAM write, emit and error strobes plus the add-or-replace sum.
   always_comb begin
      wr_d   = 1'b0;
      emit_d = 1'b0;
      err_d  = 1'b0;
      sum_d  = (state_q == S_FIRST) ? AW'(power2) : ram_rd + AW'(power2);
      if (ctrl2.valid && state_q != S_RESYNC) begin
         if (idx_err) begin
            err_d = 1'b1;
         end else begin
            wr_d   = (state_q == S_FIRST) || (state_q == S_ACCUM);
            emit_d = (state_q == S_LAST) || (state_q == S_FIRST && n_eff == '0);
         end
      end
   end

   // Stage 3 register: accumulated value and strobes headed for write-back.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         wr_q   <= 1'b0;
         emit_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         emit_q  <= emit_d;
         err_q   <= err_d;
         ctrl3_q <= ctrl2;
         sum_q   <= sum_d;
         shift_q <= n_eff;
      end
   end

   // Stage 4 accumulator write-back; RAM contents survive reset by design.
   always_ff @(posedge Clk) begin
      if (wr_q) acc_ram[ctrl3_q.data_index] <= sum_q;
   end

   // Stage 4 output register with the truncating average.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         out_valid_q <= 1'b0;
         out_err_q   <= 1'b0;
      end else begin
         out_valid_q <= emit_q;
         out_err_q   <= err_q;
         out_idx_q   <= ctrl3_q.data_index;
         out_last_q  <= ctrl3_q.last;
         out_rev_q   <= ctrl3_q.reverse;
         out_tag_q   <= ctrl3_q.tag;
         out_power_q <= OUTPUT_WIDTH'(sum_q >> shift_q);
      end
   end

   assign bus.Output_valid   = out_valid_q;
   assign bus.Error_index    = out_err_q;
   assign bus.Output_index   = out_idx_q;
   assign bus.Output_last    = out_last_q;
   assign bus.Output_reverse = out_rev_q;
   assign bus.Output_tag     = out_tag_q;
   assign bus.Output_power   = out_power_q;
endmodule

// File: doc/fft_32_power_integrator.md
Name: fft_32_power_integrator

Overview:
- Sits directly downstream of the 32-point FFT.
- Converts each FFT output bin to power, i^2 + q^2.
- Accumulates per-bin power over 2^N consecutive frames and emits one averaged 32-bin spectrum frame per integration.
- Feeds detection/threshold logic; consumes the FFT output control struct unchanged.

Parameters:
- INPUT_DATA_WIDTH, 21, signed width of FFT output I/Q.
- MAX_FRAMES_LOG2, 8, largest supported integration exponent.
- OUTPUT_WIDTH, 2*INPUT_DATA_WIDTH, width of averaged power output.

Ports:
- Clk  in  1  clock.
- Rst  in  1  reset: synchronous, active-low.
- Input_control  in  fft32_control_t  valid/last/reverse/data_index(5b)/tag(8b) from FFT.
- Input_i  in  INPUT_DATA_WIDTH  signed I.
- Input_q  in  INPUT_DATA_WIDTH  signed Q.
- Num_frames_log2  in  clog2(MAX_FRAMES_LOG2+1)  integration exponent N; values > MAX clamp to MAX.
- Output_valid  out  1  averaged bin valid.
- Output_index  out  5  bin index.
- Output_last  out  1  high on bin 31.
- Output_reverse  out  1  reverse flag of final frame.
- Output_tag  out  8  tag of final frame of integration.
- Output_power  out  OUTPUT_WIDTH  unsigned averaged power.
- Error_index  out  1  one-cycle pulse on data_index sequence error.

Behaviour:
- Reset (Rst=0 at posedge): Output_valid=0, Error_index=0, FSM=S_FIRST, expected index=0, frame counter=0. Other outputs don't-care. Accumulator RAM is not cleared; S_FIRST overwrites it.
- Input samples may arrive with arbitrary idle gaps (valid low). No backpressure.
- Pipeline, fixed 4-cycle latency from input valid to Output_valid:
  - s1: register i*i and q*q.
  - s2: sum to 2W bits unsigned; max 2^(2W-1), no overflow.
  - s3: RAM read addressed by data_index, add or replace.
  - s4: RAM write / output register.
- Accumulator width 2W+MAX_FRAMES_LOG2. Saturation is never needed.
- RMW hazard: one address is revisited no sooner than 32 valid samples later, and pipeline depth is < 32, so no forwarding is required.
- Index check: data_index must equal the expected counter, which increments per valid sample and wraps 31->0. last must coincide with index 31.
- FSM states:
  - S_FIRST: on index 0, latch N. Write power to RAM (replace). On last: go to S_LAST if N=1, S_ACCUM if N>=2, or stay in S_FIRST with output enabled if N=0.
  - S_ACCUM: RAM += power. On last, frame counter increments; when counter = 2^N-2, go to S_LAST.
  - S_LAST: emit (RAM + power) >> N per bin, with index/last/reverse/tag of the current sample. On last, go to S_FIRST.
  - S_RESYNC: entered on any index error from any state. Error_index pulses once, the integration is discarded, and no output is produced. Stay until an input with last=1 (inclusive), then go to S_FIRST with expected index 0.
- N=0 acts as power passthrough: every frame is emitted, with S_FIRST output-enabled.
- Changing Num_frames_log2 mid-integration has no effect until the next S_FIRST index-0 sample.
- Averaging uses floor (truncating right shift).
- Reset mid-integration: partial frames are discarded. No spurious Output_valid for in-flight pipeline samples; the s1-s4 valid bits are cleared.

Decomposition:
- dsp_pkg holds:
  - the existing fft32_control_t;
  - a new fft32_power_integ_state_t enum (S_FIRST, S_ACCUM, S_LAST, S_RESYNC);
  - the constant FFT32_LENGTH=32.
- One sub-module, fft_32_power_calc: the 2-stage registered i^2+q^2 with valid/control passthrough. It is reusable by other detectors.
- The accumulator RAM is an inferred 32-entry simple dual-port array, kept local.

Test Plan:
1. N=0, one frame with i=3, q=-4 on all bins -> 32 outputs, power=25, index 0..31, last only on 31, first output 4 cycles after first input.
2. N=2, four frames with bin k: i=k, q=0 -> no output during frames 1-3. Frame 4 outputs power=k^2, tag equals frame 4 tag.
3. N=1, frame A power 10 (i=1,q=3), frame B power 13 (i=2,q=3) on all bins -> output 11 (floor 23/2) on all bins.
4. Sequence 0,1,3,...: Error_index pulses exactly once at index 3; the integration yields no output. The next two clean N=1 frames output correct values.
5. Full scale: i=q=-2^20, N=4, 16 frames -> output power 2^41 exactly, no wrap. Random idle gaps of 0-5 cycles between samples give the same result.
6. N=2, Rst=0 for 1 cycle after 2 frames, then 4 fresh frames of power 25 -> nothing emitted before or during reset. A single output frame follows with power 25, uncontaminated by the earlier frames.
